// File: rtl/div_ratio_ctrl_pkg.sv
// Shared definitions for the runtime-programmable clock-divide controller:
// controller states and the divide-ratio legality check.
package div_ratio_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_PEND = 2'd2
  } div_state_e;

  // A ratio is legal when it is nonzero and fits in 'width' bits.
  function automatic logic ratio_is_legal(input longint unsigned ratio,
                                          input int unsigned      width);
    longint unsigned max_ratio;
    max_ratio = (64'd1 << width) - 64'd1;
    return (ratio != 64'd0) && (ratio <= max_ratio);
  endfunction

endpackage

// File: rtl/div_ratio_ctrl_phase_cnt.sv
// Period counter for the divider: counts 0..cur_div-1, flags the last
// cycle of each period (wrap) and registers the divided waveform, which
// goes high for the final ceil(N/2) counts and lags the counter by a cycle.
module div_phase_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] cur_div,
  output logic             wrap,
  output logic             div_out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             div_out_q, div_out_d;

  // cur_div is never zero, so cur_div-1 cannot underflow.
  assign wrap    = (cnt_q == (cur_div - ONE));
  assign div_out = div_out_q;

  // Next count and phase: cleared while halted, restarted on wrap or a ratio load.
  always_comb begin
    cnt_d     = cnt_q;
    div_out_d = div_out_q;
    if (!en) begin
      cnt_d     = '0;
      div_out_d = 1'b0;
    end else begin
      div_out_d = (cnt_q >= (cur_div >> 1));
      cnt_d     = (wrap || ld) ? '0 : (cnt_q + ONE);
    end
  end

  // Counter and phase registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_out_q <= div_out_d;
    end
  end

endmodule

// File: rtl/div_ratio_ctrl.sv
// Runtime-programmable clock-divide controller. New ratios arrive over a
// valid/ready port and are applied only at a period boundary; a ratio that
// arrives mid-period is parked in a one-entry pending register (PEND state).
module div_ratio_ctrl
  import div_ratio_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             run,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_err,
  output logic             div_out,
  output logic             tick,
  output logic [WIDTH-1:0] cur_div
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             cfg_err_q, cfg_err_d;
  logic             wrap;
  logic             cnt_en;
  logic             cnt_ld;
  logic             xfer;
  logic             cfg_ok;

  // The pending slot is full exactly when the FSM sits in PEND.
  assign cfg_ready = (state_q != DIV_PEND);
  assign xfer      = cfg_valid && cfg_ready;
  assign cfg_ok    = ratio_is_legal(64'(cfg_div), WIDTH);
  assign cnt_en    = (state_q != DIV_IDLE) && run;
  assign tick      = (state_q != DIV_IDLE) && wrap;
  assign cur_div   = cur_div_q;
  assign cfg_err   = cfg_err_q;

  div_phase_cnt #(.WIDTH(WIDTH)) u_phase_cnt (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .en      (cnt_en),
    .ld      (cnt_ld),
    .cur_div (cur_div_q),
    .wrap    (wrap),
    .div_out (div_out)
  );

  // Next-state, ratio update and handshake; halting outranks a wrap.
  always_comb begin
    state_d   = state_q;
    cur_div_d = cur_div_q;
    pend_d    = pend_q;
    cfg_err_d = xfer && !cfg_ok;
    cnt_ld    = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (xfer && cfg_ok) cur_div_d = cfg_div;
        if (run) state_d = DIV_RUN;
      end
      DIV_RUN: begin
        if (!run) begin
          if (xfer && cfg_ok) cur_div_d = cfg_div;
          state_d = DIV_IDLE;
        end else if (wrap) begin
          if (xfer && cfg_ok) begin
            cur_div_d = cfg_div;
            cnt_ld    = 1'b1;
          end
        end else if (xfer && cfg_ok) begin
          pend_d  = cfg_div;
          state_d = DIV_PEND;
        end
      end
      DIV_PEND: begin
        if (!run) begin
          cur_div_d = pend_q;
          state_d   = DIV_IDLE;
        end else if (wrap) begin
          cur_div_d = pend_q;
          cnt_ld    = 1'b1;
          state_d   = DIV_RUN;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // Controller registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q   <= DIV_IDLE;
      cur_div_q <= WIDTH'(DEFAULT_DIV);
      pend_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_div_q <= cur_div_d;
      pend_q    <= pend_d;
      cfg_err_q <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Bench for div_ratio_ctrl: a period-level model (position in period,
// ratio in effect, queue of parked ratios) is compared against the DUT on
// every falling edge, alongside directed checks with hand-computed values.
module tb_div_ratio_ctrl;

  localparam int WIDTH = 8;
  localparam int DEF   = 5;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             run;
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             div_out;
  logic             tick;
  logic [WIDTH-1:0] cur_div;

  int tests_run    = 0;
  int tests_failed = 0;
  bit chk_en       = 1'b0;

  // Model state
  bit m_running = 1'b0;
  int m_pos     = 0;
  int m_ratio   = DEF;
  int m_pend[$];
  bit m_err     = 1'b0;
  bit m_dout    = 1'b0;

  div_ratio_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .div_out   (div_out),
    .tick      (tick),
    .cur_div   (cur_div)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] d, input logic r);
    cfg_valid = v;
    cfg_div   = d;
    run       = r;
  endtask

  // Advance to the next falling edge where tick is high; n = edges waited.
  task automatic wait_tick(input int max_cycles, output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (tick !== 1'b1 && n < max_cycles);
    if (tick !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL tick_timeout: no tick within %0d cycles at %0t", max_cycles, $time);
    end
  endtask

  // Period-level model, advanced on each rising edge from the sampled inputs.
  initial begin
    forever begin
      @(posedge clk_in);
      if (!rst_n) begin
        m_running = 1'b0;
        m_pos     = 0;
        m_ratio   = DEF;
        m_pend.delete();
        m_err     = 1'b0;
        m_dout    = 1'b0;
      end else begin
        bit xfer, good, last, new_dout;
        xfer     = cfg_valid && (m_pend.size() == 0);
        good     = xfer && (cfg_div != 0);
        last     = (m_pos == m_ratio - 1);
        new_dout = m_running && run && (m_pos >= m_ratio - (m_ratio + 1) / 2);
        m_err    = xfer && (cfg_div == 0);
        if (!m_running) begin
          if (good) m_ratio = int'(cfg_div);
          m_running = run;
          m_pos     = 0;
        end else if (!run) begin
          if (m_pend.size() != 0) m_ratio = m_pend.pop_front();
          else if (good) m_ratio = int'(cfg_div);
          m_running = 1'b0;
          m_pos     = 0;
        end else if (last) begin
          if (m_pend.size() != 0) m_ratio = m_pend.pop_front();
          else if (good) m_ratio = int'(cfg_div);
          m_pos = 0;
        end else begin
          m_pos++;
          if (good) m_pend.push_back(int'(cfg_div));
        end
        m_dout = new_dout;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk_in) begin
    if (chk_en) begin
      check_output("model_tick", 32'(tick), 32'(m_running && (m_pos == m_ratio - 1)));
      check_output("model_div_out", 32'(div_out), 32'(m_dout));
      check_output("model_cfg_ready", 32'(cfg_ready), 32'(m_pend.size() == 0));
      check_output("model_cfg_err", 32'(cfg_err), 32'(m_err));
      check_output("model_cur_div", 32'(cur_div), 32'(m_ratio));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int ones;
    rst_n = 1'b0;
    apply_stimulus(1'b0, '0, 1'b0);
    @(negedge clk_in);
    chk_en = 1'b1;

    // Reset values
    check_output("rst_cur_div", 32'(cur_div), 32'd5);
    check_output("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check_output("rst_tick", 32'(tick), 32'd0);
    check_output("rst_div_out", 32'(div_out), 32'd0);

    // Default ratio 5: period and duty
    rst_n = 1'b1;
    apply_stimulus(1'b0, '0, 1'b1);
    wait_tick(20, n);
    wait_tick(20, n);
    check_output("period_5", 32'(n), 32'd5);
    ones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      if (div_out === 1'b1) ones++;
    end
    check_output("div5_high_cycles", 32'(ones), 32'd3);

    // Mid-period update to 8 goes through PEND
    @(negedge clk_in);
    @(negedge clk_in);
    apply_stimulus(1'b1, 8'd8, 1'b1);
    @(negedge clk_in);
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("pend_ready_low", 32'(cfg_ready), 32'd0);
    wait_tick(20, n);
    check_output("pend_old_ratio", 32'(cur_div), 32'd5);
    wait_tick(20, n);
    check_output("period_8", 32'(n), 32'd8);
    check_output("ratio_8", 32'(cur_div), 32'd8);
    check_output("ready_back", 32'(cfg_ready), 32'd1);

    // Update to 3 on the wrap edge bypasses PEND
    apply_stimulus(1'b1, 8'd3, 1'b1);
    @(negedge clk_in);
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("wrap_ready_high", 32'(cfg_ready), 32'd1);
    check_output("wrap_ratio_3", 32'(cur_div), 32'd3);
    wait_tick(20, n);
    check_output("period_3", 32'(n), 32'd2);

    // Zero ratio in RUN
    apply_stimulus(1'b1, 8'd0, 1'b1);
    @(negedge clk_in);
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("zero_run_err", 32'(cfg_err), 32'd1);
    check_output("zero_run_ratio", 32'(cur_div), 32'd3);
    @(negedge clk_in);
    check_output("zero_run_err_clear", 32'(cfg_err), 32'd0);

    // Halt, then zero ratio in IDLE
    apply_stimulus(1'b0, '0, 1'b0);
    @(negedge clk_in);
    check_output("halt_tick", 32'(tick), 32'd0);
    check_output("halt_div_out", 32'(div_out), 32'd0);
    apply_stimulus(1'b1, 8'd0, 1'b0);
    @(negedge clk_in);
    apply_stimulus(1'b0, '0, 1'b0);
    check_output("zero_idle_err", 32'(cfg_err), 32'd1);
    check_output("zero_idle_ratio", 32'(cur_div), 32'd3);

    // Ratio 1: tick every cycle, div_out steady high
    apply_stimulus(1'b1, 8'd1, 1'b1);
    @(negedge clk_in);
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("div1_ratio", 32'(cur_div), 32'd1);
    check_output("div1_first_tick", 32'(tick), 32'd1);
    check_output("div1_first_div_out", 32'(div_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      check_output("div1_tick", 32'(tick), 32'd1);
      check_output("div1_div_out", 32'(div_out), 32'd1);
    end
    apply_stimulus(1'b0, '0, 1'b0);
    @(negedge clk_in);
    check_output("div1_stop_div_out", 32'(div_out), 32'd0);
    check_output("div1_stop_tick", 32'(tick), 32'd0);

    // Reset while a ratio is pending
    apply_stimulus(1'b1, 8'd10, 1'b0);
    @(negedge clk_in);
    apply_stimulus(1'b0, '0, 1'b1);
    @(negedge clk_in);
    @(negedge clk_in);
    apply_stimulus(1'b1, 8'd6, 1'b1);
    @(negedge clk_in);
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("pend6_ready_low", 32'(cfg_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk_in);
    check_output("rst_pend_ratio", 32'(cur_div), 32'd5);
    check_output("rst_pend_ready", 32'(cfg_ready), 32'd1);
    check_output("rst_pend_tick", 32'(tick), 32'd0);
    check_output("rst_pend_div_out", 32'(div_out), 32'd0);
    check_output("rst_pend_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    wait_tick(20, n);
    wait_tick(20, n);
    check_output("period_after_reset", 32'(n), 32'd5);

    apply_stimulus(1'b0, '0, 1'b0);
    repeat (3) @(negedge clk_in);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
